// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the keypad matrix scanner:
//   - kp_state_e   : scanner state (SCAN, DEBOUNCE, HELD)
//   - MAX_LINES    : largest supported row/column count
//   - LINE_IDX_W   : index width covering MAX_LINES
//   - code_width() : key_code width for a given matrix size
//   - first_set()  : lowest set bit index of a row vector
// -----------------------------------------------------------------------------
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } kp_state_e;

  localparam int unsigned MAX_LINES  = 8;
  localparam int unsigned LINE_IDX_W = $clog2(MAX_LINES);

  function automatic int unsigned code_width(input int unsigned n_rows,
                                             input int unsigned n_cols);
    return $clog2(n_rows * n_cols);
  endfunction

  // Lowest set index wins, so simultaneous presses on one column resolve to
  // the lowest row.
  function automatic logic [LINE_IDX_W-1:0] first_set(input logic [MAX_LINES-1:0] rows);
    logic [LINE_IDX_W-1:0] idx;
    idx = '0;
    for (int i = MAX_LINES - 1; i >= 0; i--) begin
      if (rows[i]) idx = LINE_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_debounce_ctr.sv
// -----------------------------------------------------------------------------
// debounce_ctr
// Tick-gated saturating counter shared by the DEBOUNCE and HELD phases.
// Ports:
//   clk, rst_i : clock, synchronous active-high reset
//   tick       : advance enable (scan tick)
//   clr        : on tick, restart the count (to 1 if inc is also set, else 0)
//   inc        : on tick, count one more stable sample
//   tc         : high when one more increment reaches TERM
// -----------------------------------------------------------------------------
module debounce_ctr #(
  parameter int unsigned TERM = 3,
  parameter int unsigned W    = 4
) (
  input  logic clk,
  input  logic rst_i,
  input  logic tick,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (tick) begin
      if (clr) begin
        cnt_d = inc ? W'(1) : '0;
      end else if (inc && (cnt_q != W'(TERM))) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Look-ahead flag: lets the controller act on the same tick the count
  // would reach TERM instead of one tick later.
  assign tc = (int'(cnt_q) + 1) >= int'(TERM);

  always_ff @(posedge clk) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
// Drives an active-low one-hot column strobe that rotates on each scan tick,
// samples active-low rows, debounces one press at a time and reports one key
// code per accepted press (key = row*N_COLS + col).
// Ports:
//   clk, rst_i  : clock, synchronous active-high reset
//   ena         : one-cycle scan tick; all state advances only on ena
//   rows_ni     : matrix rows, active-low, asynchronous to clk
//   cols_no     : column strobe, active-low one-hot, registered
//   key_code    : last accepted key, held until the next accepted press
//   key_valid   : one-cycle pulse when key_code updates
//   key_down    : high while the accepted key is held
//   key_release : (KEYPAD_RELEASE_EVT_EN only) one-cycle pulse on release
// Optional feature macro: KEYPAD_RELEASE_EVT_EN
// -----------------------------------------------------------------------------
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter  int unsigned N_COLS    = 4,
  parameter  int unsigned N_ROWS    = 4,
  parameter  int unsigned DEB_TICKS = 3,
  localparam int unsigned CODE_W    = code_width(N_ROWS, N_COLS)
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              ena,
  input  logic [N_ROWS-1:0] rows_ni,
  output logic [N_COLS-1:0] cols_no,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_down
`ifdef KEYPAD_RELEASE_EVT_EN
  ,
  output logic              key_release
`endif
);

  logic [N_ROWS-1:0]     rows_q;
  logic [MAX_LINES-1:0]  rows_wide;
  kp_state_e             state_q, state_d;
  logic [LINE_IDX_W-1:0] col_q, col_d, col_next;
  logic [LINE_IDX_W-1:0] cand_row_q, cand_row_d;
  logic [N_COLS-1:0]     cols_no_q, cols_no_d;
  logic [CODE_W-1:0]     key_code_q, key_code_d;
  logic                  key_valid_q, key_valid_d;
  logic                  key_down_q, key_down_d;
  logic                  ctr_clr, ctr_inc, ctr_tc;
`ifdef KEYPAD_RELEASE_EVT_EN
  logic                  key_release_q, key_release_d;
`endif

  assign rows_wide = MAX_LINES'(rows_q);
  assign col_next  = (col_q == LINE_IDX_W'(N_COLS - 1)) ? '0 : col_q + 1'b1;

  debounce_ctr #(
    .TERM (DEB_TICKS),
    .W    (4)
  ) u_deb (
    .clk   (clk),
    .rst_i (rst_i),
    .tick  (ena),
    .clr   (ctr_clr),
    .inc   (ctr_inc),
    .tc    (ctr_tc)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and no latch is inferred.
    state_d     = state_q;
    col_d       = col_q;
    cand_row_d  = cand_row_q;
    key_code_d  = key_code_q;
    key_down_d  = key_down_q;
    key_valid_d = 1'b0;
    ctr_clr     = 1'b0;
    ctr_inc     = 1'b0;
`ifdef KEYPAD_RELEASE_EVT_EN
    key_release_d = 1'b0;
`endif

    if (ena) begin
      unique case (state_q)
        SCAN: begin
          if (rows_q != '0) begin
            // Column stays put: the candidate key lives on the driven column.
            cand_row_d = first_set(rows_wide);
            ctr_clr    = 1'b1;
            ctr_inc    = 1'b1;
            state_d    = DEBOUNCE;
          end else begin
            col_d = col_next;
          end
        end
        DEBOUNCE: begin
          if (rows_wide[cand_row_q]) begin
            if (ctr_tc) begin
              key_code_d  = CODE_W'(int'(cand_row_q) * int'(N_COLS) + int'(col_q));
              key_valid_d = 1'b1;
              key_down_d  = 1'b1;
              ctr_clr     = 1'b1;
              state_d     = HELD;
            end else begin
              ctr_inc = 1'b1;
            end
          end else begin
            ctr_clr = 1'b1;
            col_d   = col_next;
            state_d = SCAN;
          end
        end
        HELD: begin
          // Only the accepted row is watched; other presses are ignored.
          if (!rows_wide[cand_row_q]) begin
            if (ctr_tc) begin
              key_down_d = 1'b0;
              ctr_clr    = 1'b1;
              col_d      = col_next;
              state_d    = SCAN;
`ifdef KEYPAD_RELEASE_EVT_EN
              key_release_d = 1'b1;
`endif
            end else begin
              ctr_inc = 1'b1;
            end
          end else begin
            ctr_clr = 1'b1;
          end
        end
        default: state_d = SCAN;
      endcase
    end

    // Strobe is a pure function of the column index, so it is always one-hot.
    cols_no_d = ~(N_COLS'(1) << col_d);
  end

  always_ff @(posedge clk) begin
    // NOTE: flops use non-blocking assignments so every register samples
    // values from before this edge, independent of statement order.
    rows_q <= ~rows_ni;
    if (rst_i) begin
      state_q     <= SCAN;
      col_q       <= '0;
      cand_row_q  <= '0;
      cols_no_q   <= ~N_COLS'(1);
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
`ifdef KEYPAD_RELEASE_EVT_EN
      key_release_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      cand_row_q  <= cand_row_d;
      cols_no_q   <= cols_no_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
`ifdef KEYPAD_RELEASE_EVT_EN
      key_release_q <= key_release_d;
`endif
    end
  end

  assign cols_no   = cols_no_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_down  = key_down_q;
`ifdef KEYPAD_RELEASE_EVT_EN
  assign key_release = key_release_q;
`endif

endmodule
